// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder mem_rd/mem_wr requests into one req/ack word
// transaction, stalls the core meanwhile, and reports alignment/funct3/timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  // state  | meaning
  // IDLE   | waiting for mem_rd_i/mem_wr_i; faults are decided here
  // REQ    | mem_req_o held until ack or timeout
  // DONE   | one-cycle retire slot, request inputs ignored
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;

  logic        req;
  logic        is_store;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'd0, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b101:  extend = {16'd0, h};
      default: extend = word;
    endcase
  endfunction

  always_comb begin
    req      = mem_rd_i | mem_wr_i;
    is_store = mem_wr_i;
    if (is_store)
      illegal = (funct3_i > 3'b010);
    else
      illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    misaligned = ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                 ((funct3_i[1:0] == 2'b01) && addr_i[0]);

    be_next    = 4'b1111;
    wdata_next = wdata_i;
    if (is_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr_i[1:0];
          wdata_next = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{wdata_i[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = wdata_i;
        end
      endcase
    end

    load_ext = extend(op_funct3, op_off, mem_rdata_i);
    stall_o  = !rst_i && (((state == S_IDLE) && req) || (state == S_REQ));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      op_funct3    <= 3'd0;
      op_off       <= 2'd0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= 4'd0;
      mem_addr_o   <= 32'd0;
      mem_wdata_o  <= 32'd0;
      rdata_o      <= 32'd0;
      done_o       <= 1'b0;
      fault_o      <= 1'b0;
      fault_code_o <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (illegal || misaligned) begin
              // illegal funct3 outranks misalignment
              state        <= S_DONE;
              done_o       <= 1'b1;
              fault_o      <= 1'b1;
              fault_code_o <= illegal ? FC_ILLEGAL : FC_MISALIGN;
              rdata_o      <= 32'd0;
            end else begin
              state       <= S_REQ;
              cnt         <= 8'd0;
              op_funct3   <= funct3_i;
              op_off      <= addr_i[1:0];
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_be_o    <= be_next;
              mem_wdata_o <= wdata_next;
            end
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            state        <= S_DONE;
            mem_req_o    <= 1'b0;
            rdata_o      <= mem_we_o ? 32'd0 : load_ext;
            done_o       <= 1'b1;
            fault_code_o <= 2'd0;
          end else if (cnt == CNT_LAST) begin
            state        <= S_DONE;
            mem_req_o    <= 1'b0;
            rdata_o      <= 32'd0;
            done_o       <= 1'b1;
            fault_o      <= 1'b1;
            fault_code_o <= FC_TIMEOUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_o  <= 1'b0;
          fault_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
